// File: rtl/int_ctl_pkg.sv
// Shared constants for the PDP-8/e interrupt controller: major-state codes, opcodes and FSM encoding.
package int_ctl_pkg;

    localparam int unsigned STATE_W    = 5;
    localparam int unsigned WORD_W     = 12;
    localparam int unsigned SRC_W      = 3;
    localparam int unsigned WAIT_LIMIT = 8;
    localparam int unsigned WAIT_W     = $clog2(WAIT_LIMIT);

    // Major state / phase codes: Fetch, Defer, Execute, Halt (panel), phases 0..3.
    localparam logic [STATE_W-1:0] F0 = 5'd0,  F1 = 5'd1,  F2 = 5'd2,  F3 = 5'd3;
    localparam logic [STATE_W-1:0] D0 = 5'd4,  D1 = 5'd5,  D2 = 5'd6,  D3 = 5'd7;
    localparam logic [STATE_W-1:0] E0 = 5'd8,  E1 = 5'd9,  E2 = 5'd10, E3 = 5'd11;
    localparam logic [STATE_W-1:0] H0 = 5'd12, H1 = 5'd13, H2 = 5'd14, H3 = 5'd15;

    localparam logic [2:0]        JMS        = 3'o4;
    localparam logic [WORD_W-1:0] JMPI       = 12'o5400;
    localparam logic [WORD_W-1:0] ION        = 12'o6001;
    localparam logic [WORD_W-1:0] FORCED_JMS = 12'o4000;

    localparam logic [SRC_W-1:0]  SRC_NONE   = 3'o7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAKE    = 2'd1,
        WAIT_E0 = 2'd2,
        RUN     = 2'd3
    } int_fsm_t;

    function automatic logic is_halt(input logic [STATE_W-1:0] s);
        return (s == H0) || (s == H1) || (s == H2) || (s == H3);
    endfunction

endpackage

// File: rtl/int_sync.sv
// Multi-stage synchroniser for asynchronous level inputs, cleared synchronously by clr.
module int_sync
    import int_ctl_pkg::*;
#(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] pipe [STAGES];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign q = pipe[STAGES-1];

endmodule

// File: rtl/int_ctl.sv
// Interrupt collector and acceptance sequencer: forces JMS 0 at instruction end and tracks the forced cycle.
// Build option INT_PRIO_EN: latch the lowest-numbered active device into irq_src at acceptance.
module int_ctl
    import int_ctl_pkg::*;
#(
    parameter int unsigned NDEV        = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    input  logic [0:WORD_W-1]  instruction,
    input  logic               instr_done,
    input  logic               clear,
    input  logic               int_ena,
    input  logic               int_inh,
    input  logic               UI,
    input  logic [NDEV-1:0]    dev_irq,
    output logic               irq,
    output logic               force_jms,
    output logic               int_in_prog,
    output logic               int_ack,
    output logic [SRC_W-1:0]   irq_src
);

    logic              flush;
    logic [NDEV-1:0]   irq_sync;
    int_fsm_t          fsm_q, fsm_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              accept;
    logic              force_d;
    logic              in_prog_d;

    assign flush = reset | clear;

    int_sync #(
        .WIDTH  (NDEV),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .clr (flush),
        .d   (dev_irq),
        .q   (irq_sync)
    );

    // ION at instr_done is refused even if a stale int_ena is still high.
    assign accept = instr_done & int_ena & ~int_inh & irq & ~is_halt(state)
                  & (instruction != ION);

    always_comb begin
        fsm_d     = fsm_q;
        wait_d    = wait_q;
        force_d   = 1'b0;
        in_prog_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (accept) begin
                    fsm_d = TAKE;
                end
            end
            TAKE: begin
                fsm_d  = WAIT_E0;
                wait_d = '0;
            end
            WAIT_E0: begin
                if (state == E0) begin
                    fsm_d = RUN;
                end else if (wait_q == WAIT_W'(WAIT_LIMIT - 1)) begin
                    fsm_d = IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            RUN: begin
                if (state == E3) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
        force_d   = (fsm_d == TAKE);
        in_prog_d = (fsm_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            fsm_q       <= IDLE;
            wait_q      <= '0;
            irq         <= 1'b0;
            force_jms   <= 1'b0;
            int_in_prog <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            wait_q      <= wait_d;
            irq         <= (|irq_sync) | UI;
            force_jms   <= force_d;
            int_in_prog <= in_prog_d;
        end
    end

    // Acknowledge must coincide with the E3 phase itself, so it is decoded from the live state code.
    assign int_ack = (fsm_q == RUN) & (state == E3) & ~flush;

`ifdef INT_PRIO_EN
    logic [SRC_W-1:0] prio_c;

    always_comb begin
        prio_c = SRC_NONE;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (irq_sync[i]) begin
                prio_c = SRC_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            irq_src <= '0;
        end else if (fsm_d == TAKE) begin
            irq_src <= prio_c;
        end
    end
`else
    assign irq_src = '0;
`endif

endmodule

// File: tb/tb_int_ctl.sv
// Bench for int_ctl: acceptance vector table, hand-written multi-cycle sequences, randomised run vs. reference model.
module tb_int_ctl;
    import int_ctl_pkg::*;

    localparam int unsigned NDEV  = 8;
    localparam int unsigned S     = 2;
    localparam int          NRAND = 4000;
    localparam int          NV    = 11;
`ifdef INT_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [4:0]  state;
    logic [0:11] instruction;
    logic        instr_done;
    logic        clear;
    logic        int_ena;
    logic        int_inh;
    logic        UI;
    logic [7:0]  dev_irq;
    logic        irq;
    logic        force_jms;
    logic        int_in_prog;
    logic        int_ack;
    logic [2:0]  irq_src;

    int_ctl #(.NDEV(NDEV), .SYNC_STAGES(S)) dut (
        .clk         (clk),
        .reset       (reset),
        .state       (state),
        .instruction (instruction),
        .instr_done  (instr_done),
        .clear       (clear),
        .int_ena     (int_ena),
        .int_inh     (int_inh),
        .UI          (UI),
        .dev_irq     (dev_irq),
        .irq         (irq),
        .force_jms   (force_jms),
        .int_in_prog (int_in_prog),
        .int_ack     (int_ack),
        .irq_src     (irq_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] xsrc(input logic [2:0] v);
        return PRIO ? v : 3'o0;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; clear = 1'b0; instr_done = 1'b0; int_ena = 1'b0; int_inh = 1'b0;
        UI = 1'b0; dev_irq = '0; state = F0; instruction = 12'o7000;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Acceptance vectors: request/enable conditions held, then a single instr_done.
    typedef struct {
        string      name;
        logic       ena;
        logic       inh;
        logic       ui;
        logic [7:0] dev;
        logic [4:0] st;
        logic [11:0] instr;
        logic       irq_e;
        logic       take_e;
        logic [2:0] src_e;
    } vec_t;

    vec_t vecs [NV];

    // Reference model: request levels come from a per-cycle history, acceptance from the rules directly.
    logic [7:0] dev_log [NRAND];
    bit         fl_log  [NRAND];
    bit         m_irq, m_active, m_take, m_run;
    int         m_wait;
    logic [2:0] m_src;

    function automatic logic [7:0] sync_at(input int k);
        for (int j = k - int'(S); j < k; j++) begin
            if (j < 0) return 8'h00;
            if (fl_log[j]) return 8'h00;
        end
        return dev_log[k - int'(S)];
    endfunction

    function automatic logic [2:0] lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'o7;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vecs[0]  = '{"dev2",      1'b1, 1'b0, 1'b0, 8'h04, F3, 12'o7000, 1'b1, 1'b1, 3'd2};
        vecs[1]  = '{"ena_off",   1'b0, 1'b0, 1'b0, 8'hFF, F3, 12'o7000, 1'b1, 1'b0, 3'd0};
        vecs[2]  = '{"inhibit",   1'b1, 1'b1, 1'b0, 8'h01, F3, JMPI,     1'b1, 1'b0, 3'd0};
        vecs[3]  = '{"ui_only",   1'b1, 1'b0, 1'b1, 8'h00, F3, 12'o7000, 1'b1, 1'b1, 3'd7};
        vecs[4]  = '{"halt_h1",   1'b1, 1'b0, 1'b0, 8'h04, H1, 12'o7000, 1'b1, 1'b0, 3'd0};
        vecs[5]  = '{"ion_instr", 1'b1, 1'b0, 1'b0, 8'h04, F3, ION,      1'b1, 1'b0, 3'd0};
        vecs[6]  = '{"no_req",    1'b1, 1'b0, 1'b0, 8'h00, F3, 12'o7000, 1'b0, 1'b0, 3'd0};
        vecs[7]  = '{"dev0_dev7", 1'b1, 1'b0, 1'b0, 8'h81, D3, 12'o1234, 1'b1, 1'b1, 3'd0};
        vecs[8]  = '{"dev5_dev6", 1'b1, 1'b0, 1'b0, 8'h60, E3, 12'o4000, 1'b1, 1'b1, 3'd5};
        vecs[9]  = '{"dev7",      1'b1, 1'b0, 1'b0, 8'h80, F3, 12'o7000, 1'b1, 1'b1, 3'd7};
        vecs[10] = '{"halt_h3",   1'b1, 1'b0, 1'b1, 8'h10, H3, 12'o7000, 1'b1, 1'b0, 3'd0};

        // Full interrupt: reset state, 3-clock sync latency, forced JMS through E3.
        do_reset();
        dev_irq = 8'h04; int_ena = 1'b1; state = F1;
        #1;
        chk1("rst_irq", irq, 1'b0);
        chk1("rst_force", force_jms, 1'b0);
        chk1("rst_inprog", int_in_prog, 1'b0);
        chk1("rst_ack", int_ack, 1'b0);
        chk3("rst_src", irq_src, 3'd0);
        cyc(); #1; chk1("lat_c2", irq, 1'b0);
        cyc(); #1; chk1("lat_c3", irq, 1'b0);
        cyc(); #1; chk1("lat_c4", irq, 1'b1);
        cyc(); instr_done = 1'b1; state = F3; #1;
        chk1("pre_take_force", force_jms, 1'b0);
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("take_force", force_jms, 1'b1);
        chk1("take_inprog", int_in_prog, 1'b1);
        chk3("take_src", irq_src, xsrc(3'd2));
        cyc(); state = E0; #1;
        chk1("e0_force", force_jms, 1'b0);
        chk1("e0_inprog", int_in_prog, 1'b1);
        cyc(); state = E1; #1;
        chk1("e1_inprog", int_in_prog, 1'b1);
        chk1("e1_ack", int_ack, 1'b0);
        cyc(); state = E2; #1;
        chk1("e2_ack", int_ack, 1'b0);
        cyc(); state = E3; #1;
        chk1("e3_ack", int_ack, 1'b1);
        chk1("e3_inprog", int_in_prog, 1'b1);
        cyc(); state = F0; #1;
        chk1("post_ack", int_ack, 1'b0);
        chk1("post_inprog", int_in_prog, 1'b0);
        chk3("post_src_held", irq_src, xsrc(3'd2));

        // Acceptance table.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            do_reset();
            int_ena = v.ena; int_inh = v.inh; UI = v.ui; dev_irq = v.dev; state = F1;
            repeat (4) cyc();
            instr_done = 1'b1; state = v.st; instruction = v.instr;
            #1;
            chk1($sformatf("%s_irq", v.name), irq, v.irq_e);
            cyc(); instr_done = 1'b0; state = F0; instruction = 12'o7000; #1;
            chk1($sformatf("%s_force", v.name), force_jms, v.take_e);
            chk1($sformatf("%s_inprog", v.name), int_in_prog, v.take_e);
            chk3($sformatf("%s_src", v.name), irq_src, xsrc(v.src_e));
        end

        // Inhibit holds off acceptance until the next instr_done.
        do_reset();
        dev_irq = 8'h01; int_ena = 1'b1; int_inh = 1'b1; state = F1;
        repeat (4) cyc();
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; int_inh = 1'b0; state = F0; #1;
        chk1("inh_hold", force_jms, 1'b0);
        cyc(); #1; chk1("inh_idle", force_jms, 1'b0);
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("inh_retry", force_jms, 1'b1);

        // UI reaches irq in one clock.
        do_reset();
        UI = 1'b1; int_ena = 1'b1; state = F1;
        #1; chk1("ui_c1", irq, 1'b0);
        cyc(); #1; chk1("ui_c2", irq, 1'b1);
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("ui_force", force_jms, 1'b1);
        chk3("ui_src", irq_src, xsrc(3'd7));

        // Reset during RUN aborts without acknowledge; later takes relatch the source.
        do_reset();
        dev_irq = 8'h60; int_ena = 1'b1; state = F1;
        repeat (4) cyc();
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("abort_take", force_jms, 1'b1);
        cyc(); state = E0;
        cyc(); state = E1; reset = 1'b1; #1;
        chk1("abort_e1_inprog", int_in_prog, 1'b1);
        chk1("abort_e1_ack", int_ack, 1'b0);
        cyc(); reset = 1'b0; state = E2; #1;
        chk1("abort_inprog", int_in_prog, 1'b0);
        chk3("abort_src", irq_src, 3'd0);
        cyc(); state = E3; #1;
        chk1("abort_noack", int_ack, 1'b0);
        cyc(); state = F1;
        repeat (3) cyc();
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("retake_force", force_jms, 1'b1);
        chk3("retake_src", irq_src, xsrc(3'd5));
        do_reset();
        dev_irq = 8'h81; int_ena = 1'b1; state = F1;
        repeat (4) cyc();
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("rst2_force", force_jms, 1'b1);
        chk3("rst2_src", irq_src, xsrc(3'd0));

        // Sequencer never reaches E0: give up after eight waiting clocks.
        do_reset();
        dev_irq = 8'h01; int_ena = 1'b1; state = F1;
        repeat (4) cyc();
        instr_done = 1'b1; state = F3;
        cyc(); instr_done = 1'b0; state = F0; #1;
        chk1("to_take", force_jms, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cyc(); #1;
            chk1($sformatf("to_wait%0d", i), int_in_prog, 1'b1);
        end
        cyc(); #1;
        chk1("to_expire", int_in_prog, 1'b0);
        cyc(); state = E0;
        cyc(); state = E3; #1;
        chk1("to_late_e3_ack", int_ack, 1'b0);
        chk1("to_late_inprog", int_in_prog, 1'b0);

        // Interrupts disabled: repeated instruction ends never force JMS.
        do_reset();
        dev_irq = 8'hFF; state = F1;
        repeat (4) cyc();
        for (int i = 0; i < 10; i++) begin
            instr_done = 1'b1; state = F3;
            cyc(); instr_done = 1'b0; state = F0; #1;
            chk1($sformatf("dis_irq%0d", i), irq, 1'b1);
            chk1($sformatf("dis_force%0d", i), force_jms, 1'b0);
            cyc();
        end

        // Randomised run against the reference model.
        m_irq = 0; m_active = 0; m_take = 0; m_run = 0; m_wait = 0; m_src = '0;
        for (int k = 0; k < NRAND; k++) begin
            bit         fl;
            bit         acc;
            logic [7:0] s_now;
            @(negedge clk);
            reset = (k < 2) ? 1'b1 : ($urandom_range(0, 199) == 0);
            clear = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 2))
                    0:       dev_irq = 8'h00;
                    1:       dev_irq = 8'(1 << $urandom_range(0, 7));
                    default: dev_irq = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 31) == 0) UI = ~UI;
            int_ena     = ($urandom_range(0, 7) != 0);
            int_inh     = ($urandom_range(0, 7) == 0);
            state       = 5'($urandom_range(0, 15));
            instruction = ($urandom_range(0, 7) == 0) ? ION : 12'($urandom);
            instr_done  = ($urandom_range(0, 2) == 0);
            fl          = reset || clear;
            dev_log[k]  = dev_irq;
            fl_log[k]   = fl;
            #1;
            if (k >= 1) begin
                chk1("rnd_irq", irq, m_irq);
                chk1("rnd_force", force_jms, m_take);
                chk1("rnd_inprog", int_in_prog, m_active);
                chk1("rnd_ack", int_ack, m_active && m_run && !m_take && (state == E3) && !fl);
                chk3("rnd_src", irq_src, xsrc(m_src));
            end
            if (fl) begin
                m_irq = 0; m_active = 0; m_take = 0; m_run = 0; m_wait = 0; m_src = '0;
            end else begin
                s_now = sync_at(k);
                acc = !m_active && instr_done && int_ena && !int_inh && m_irq
                      && !(state inside {H0, H1, H2, H3}) && (instruction != ION);
                if (acc) begin
                    m_active = 1; m_take = 1; m_run = 0; m_wait = 0; m_src = lowest(s_now);
                end else if (m_take) begin
                    m_take = 0;
                end else if (m_active && !m_run) begin
                    if (state == E0) begin
                        m_run = 1;
                    end else begin
                        m_wait++;
                        if (m_wait == 8) m_active = 0;
                    end
                end else if (m_active && state == E3) begin
                    m_active = 0;
                end
                m_irq = (|s_now) || UI;
            end
            if (errors >= 25) break;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/int_ctl.md
Name: int_ctl

Overview:
- Interrupt request collector and acceptance sequencer for the PDP-8/e core.
- Synchronises per-device interrupt flags and the user-mode trap (UI), and presents the combined request to the memory-extension/flag block as irq.
- At instruction end, when interrupts are enabled and not inhibited, tells the major-state sequencer to force JMS 0 into field 0.
- Drives int_in_prog through that forced execute cycle, which is what clears int_ena and saves the fields.

Parameters:
- NDEV, 8, number of device interrupt lines.
- SYNC_STAGES, 2, synchroniser depth per device line (legal 2..3).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- state  input  5  current major state/phase (F0..H3 codes, shared parameters)
- instruction  input  12 [0:11]  current instruction register
- instr_done  input  1  one-cycle pulse from sequencer in the last phase-3 of each instruction
- clear  input  1  CAF / front-panel clear
- int_ena  input  1  interrupt enable from flag block
- int_inh  input  1  interrupt inhibit from flag block
- UI  input  1  user-interrupt flag from flag block
- dev_irq  input  NDEV  asynchronous device flags, active-high, level
- irq  output  1  synchronised OR of devices and UI
- force_jms  output  1  one-cycle pulse: sequencer loads 12'o4000 and enters E0 next
- int_in_prog  output  1  interrupt in progress
- int_ack  output  1  one-cycle pulse at E3 of the forced JMS
- irq_src  output  3  index of the serviced device (see Optional Feature)

Behaviour:
Reset / clear:
- reset or clear: FSM to IDLE; synchroniser flops to 0; all outputs 0.
- reset has priority over clear.
- Either asserted mid-interrupt aborts the sequence. int_in_prog drops on the next edge; no int_ack.

Synchroniser:
- Each dev_irq bit passes through SYNC_STAGES flops, giving irq_sync.
- irq is registered: irq = |irq_sync | UI.
- Latency from a dev_irq edge to irq is SYNC_STAGES+1 clocks. UI reaches irq in 1 clock.

FSM states:
- IDLE
  - Goes to TAKE when instr_done=1 and int_ena=1 and int_inh=0 and irq=1, all sampled on the same edge.
  - If state is H0..H3, it stays in IDLE regardless. No interrupts are taken during halt or panel operation.
- TAKE (1 cycle)
  - force_jms=1 and int_in_prog=1.
  - irq_src is latched here.
  - Goes to WAIT_E0.
- WAIT_E0
  - int_in_prog=1; waits for state==E0.
  - Timeout: if E0 is not seen within 8 clocks, returns to IDLE with int_in_prog=0. This is a sequencer-fault guard.
- RUN
  - Entered on E0.
  - int_in_prog=1 through E0..E3.
  - At E3, int_ack=1 for that cycle; next state IDLE.

Ordering and boundary rules:
- int_in_prog deasserts on the clock after E3.
- Simultaneous events:
  - instr_done while int_inh=1 (CIF pending a JMP) is not taken; acceptance is retried at the next instr_done.
  - If irq drops in the same cycle as instr_done, it is not taken.
- ION delay is handled by the flag block: int_ena rises only after the following instruction's F2, so the ION+1 instruction is always completed.
- Requests are level-sensitive. A device still asserting after int_ack re-interrupts after the next instruction once ION is executed.
- instruction is used only to suppress acceptance:
  - When instruction==12'o6001 (ION) at instr_done, acceptance is suppressed.
  - This is belt-and-braces against a stale int_ena.

Optional Feature:
- Macro: INT_PRIO_EN.
- Defined:
  - Priority encoder over irq_sync; lowest index wins.
  - irq_src is latched in TAKE and held until the next TAKE.
  - With no device active (UI-only request), irq_src=7.
- Undefined: irq_src is tied to 3'o0 and no encoder is synthesised. Software polls the skip chain.

Decomposition:
- Shared parameters file holds:
  - major-state codes F0..F3, D0..D3, E0..E3, H0..H3;
  - opcode constants JMS, JMPI;
  - FSM state encoding IDLE/TAKE/WAIT_E0/RUN;
  - constant 12'o4000 FORCED_JMS.
- One sub-module: int_sync, a parameterised SYNC_STAGES-deep synchroniser, instantiated NDEV wide.

Test Plan:
1. dev_irq=8'h04 with int_ena=1, int_inh=0 → irq=1 three clocks later. At the next instr_done, force_jms pulses once, int_in_prog stays 1 until the clock after E3, int_ack pulses at E3, and irq_src=2 (INT_PRIO_EN).
2. int_ena=0, dev_irq=8'hFF, ten instr_done pulses → irq=1 throughout, force_jms never asserts.
3. int_inh=1 at instr_done with irq=1 → no TAKE. int_inh=0 at the following instr_done → TAKE occurs.
4. UI=1, dev_irq=0 → irq=1 after 1 clock. Interrupt taken; irq_src=7 (INT_PRIO_EN) or 0 (without).
5. reset asserted during RUN at E1 → int_in_prog=0 next clock, no int_ack, FSM IDLE. A second reset with dev_irq=8'h81 → irq_src=0 after the next take.
6. state=H1 with instr_done=1, int_ena=1, irq=1 → no force_jms. TAKE in WAIT_E0 without E0 for 8 clocks → return to IDLE, int_in_prog=0.
